// File: rtl/audio_buffer_scheduler_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Package  : audio_pkg                                                     |
// | Purpose  : Shared widths, playback FSM state encoding and the output     |
// |            saturation helper for the audio buffer scheduler slice.       |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
package audio_pkg;

  localparam int c_ADDR_WIDTH = 16;
  localparam int c_DATA_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2,
    OUT   = 2'd3
  } state_t;

  // Clamp a signed value into the range of a signed number 'width' bits wide.
  function automatic logic signed [31:0] sat_to_width(input logic signed [31:0] value,
                                                      input int width);
    logic signed [31:0] w_hi;
    logic signed [31:0] w_lo;
    w_hi = (32'sd1 <<< (width - 1)) - 32'sd1;
    w_lo = -w_hi - 32'sd1;
    if (value > w_hi) begin
      return w_hi;
    end else if (value < w_lo) begin
      return w_lo;
    end
    return value;
  endfunction

endpackage
`default_nettype wire

// File: rtl/audio_buffer_scheduler_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Interface: audio_buffer_scheduler_if                                     |
// | Purpose  : Sample stream, control and BRAM port signals of the audio     |
// |            buffer scheduler. 'master' is the scheduler side, 'slave' is  |
// |            the surrounding system (sample source, BRAM, sink).           |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
interface audio_buffer_scheduler_if #(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 8,
  parameter int NUM_TAPS   = 2
);

  logic signed [DATA_WIDTH-1:0]          audio_in;
  logic                                  audio_valid_in;
  logic                                  record_in;
  logic        [NUM_TAPS*ADDR_WIDTH-1:0] tap_delay_in;
  logic        [ADDR_WIDTH-1:0]          wr_addr_out;
  logic                                  wr_en_out;
  logic        [DATA_WIDTH-1:0]          wr_data_out;
  logic        [ADDR_WIDTH-1:0]          rd_addr_out;
  logic        [DATA_WIDTH-1:0]          rd_data_in;
  logic signed [DATA_WIDTH-1:0]          audio_out;
  logic                                  audio_valid_out;
  logic        [ADDR_WIDTH:0]            rec_length_out;
  logic                                  full_out;
  logic                                  overrun_out;

  modport master (
    input  audio_in, audio_valid_in, record_in, tap_delay_in, rd_data_in,
    output wr_addr_out, wr_en_out, wr_data_out, rd_addr_out,
           audio_out, audio_valid_out, rec_length_out, full_out, overrun_out
  );

  modport slave (
    output audio_in, audio_valid_in, record_in, tap_delay_in, rd_data_in,
    input  wr_addr_out, wr_en_out, wr_data_out, rd_addr_out,
           audio_out, audio_valid_out, rec_length_out, full_out, overrun_out
  );

endinterface
`default_nettype wire

// File: rtl/audio_buffer_scheduler_read_tag_pipe.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : read_tag_pipe                                                 |
// | Purpose  : Delay line that carries {valid, tap index, skip} alongside    |
// |            each BRAM read so the tag emerges together with its data.     |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module read_tag_pipe #(
  parameter int DEPTH     = 2,
  parameter int IDX_WIDTH = 2
) (
  input  wire logic                 clk_in,
  input  wire logic                 rst_in,
  input  wire logic                 tag_valid_in,
  input  wire logic [IDX_WIDTH-1:0] tag_idx_in,
  input  wire logic                 tag_skip_in,
  output logic                      tag_valid_out,
  output logic      [IDX_WIDTH-1:0] tag_idx_out,
  output logic                      tag_skip_out
);

  logic [DEPTH-1:0]     r_valid;
  logic [DEPTH-1:0]     r_skip;
  logic [IDX_WIDTH-1:0] r_idx [DEPTH];

  // Shift every tag one stage per cycle; stage 0 takes the new tag.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_valid <= '0;
      r_skip  <= '0;
      for (int s = 0; s < DEPTH; s++) begin
        r_idx[s] <= '0;
      end
    end else begin
      r_valid[0] <= tag_valid_in;
      r_skip[0]  <= tag_skip_in;
      r_idx[0]   <= tag_idx_in;
      for (int s = 1; s < DEPTH; s++) begin
        r_valid[s] <= r_valid[s-1];
        r_skip[s]  <= r_skip[s-1];
        r_idx[s]   <= r_idx[s-1];
      end
    end
  end

  assign tag_valid_out = r_valid[DEPTH-1];
  assign tag_skip_out  = r_skip[DEPTH-1];
  assign tag_idx_out   = r_idx[DEPTH-1];

endmodule
`default_nettype wire

// File: rtl/audio_buffer_scheduler.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : audio_buffer_scheduler                                        |
// | Purpose  : Owns both ports of the shared sample BRAM. Records incoming   |
// |            samples on port A; on each playback strobe reads the dry      |
// |            sample plus NUM_TAPS echoes on port B, mixes them with        |
// |            per-tap attenuation and emits one saturated output sample.    |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module audio_buffer_scheduler
  import audio_pkg::*;
#(
  parameter int ADDR_WIDTH   = c_ADDR_WIDTH,
  parameter int DATA_WIDTH   = c_DATA_WIDTH,
  parameter int NUM_TAPS     = 2,
  parameter int READ_LATENCY = 2
) (
  input wire logic                 clk_in,
  input wire logic                 rst_in,
  audio_buffer_scheduler_if.master bus
);

  localparam int c_IDX_W = $clog2(NUM_TAPS + 1);
  localparam int c_ACC_W = DATA_WIDTH + 3;
  localparam logic [ADDR_WIDTH:0] c_FULL_LEN = {1'b1, {ADDR_WIDTH{1'b0}}};

  // ---------------- record path ----------------
  logic                  r_record_d;
  logic [ADDR_WIDTH-1:0] r_wr_ptr;
  logic [ADDR_WIDTH:0]   r_rec_len;
  logic                  w_rec_rise;
  logic [ADDR_WIDTH-1:0] w_wr_ptr_eff;
  logic [ADDR_WIDTH:0]   w_len_eff;
  logic                  w_wr_fire;

  // A new take starts at address 0 even when its first sample lands in the
  // same cycle as the record_in rising edge.
  assign w_rec_rise   = bus.record_in & ~r_record_d;
  assign w_wr_ptr_eff = w_rec_rise ? '0 : r_wr_ptr;
  assign w_len_eff    = w_rec_rise ? '0 : r_rec_len;
  assign w_wr_fire    = ~rst_in & bus.record_in & bus.audio_valid_in & (w_len_eff != c_FULL_LEN);

  assign bus.wr_en_out      = w_wr_fire;
  assign bus.wr_addr_out    = w_wr_ptr_eff;
  assign bus.wr_data_out    = w_wr_fire ? bus.audio_in : '0;
  assign bus.rec_length_out = r_rec_len;
  assign bus.full_out       = (r_rec_len == c_FULL_LEN);

  // Write pointer and recorded length; a rising record_in restarts both.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_record_d <= 1'b0;
      r_wr_ptr   <= '0;
      r_rec_len  <= '0;
    end else begin
      r_record_d <= bus.record_in;
      if (w_wr_fire) begin
        r_wr_ptr  <= w_wr_ptr_eff + ADDR_WIDTH'(1);
        r_rec_len <= w_len_eff + (ADDR_WIDTH+1)'(1);
      end else if (w_rec_rise) begin
        r_wr_ptr  <= '0;
        r_rec_len <= '0;
      end
    end
  end

  // ---------------- playback path ----------------
  state_t                       r_state;
  logic [ADDR_WIDTH-1:0]        r_play_ptr;
  logic [ADDR_WIDTH-1:0]        r_base_ptr;
  logic [ADDR_WIDTH-1:0]        r_delay [NUM_TAPS];
  logic [c_IDX_W-1:0]           r_issue_idx;
  logic [ADDR_WIDTH-1:0]        r_rd_addr;
  logic                         r_tag_valid;
  logic [c_IDX_W-1:0]           r_tag_idx;
  logic                         r_tag_skip;
  logic signed [c_ACC_W-1:0]    r_acc;
  logic signed [DATA_WIDTH-1:0] r_audio_out;
  logic                         r_audio_valid;
  logic                         r_overrun;

  logic                         w_strobe_play;
  logic [ADDR_WIDTH-1:0]        w_sel_delay;
  logic                         w_sel_skip;
  logic [ADDR_WIDTH-1:0]        w_sel_addr;
  logic                         w_ret_valid;
  logic [c_IDX_W-1:0]           w_ret_idx;
  logic                         w_ret_skip;
  logic signed [c_ACC_W-1:0]    w_ret_ext;
  logic signed [c_ACC_W-1:0]    w_ret_shift;
  logic signed [c_ACC_W-1:0]    w_contrib;
  logic signed [c_ACC_W-1:0]    w_sum;
  logic signed [DATA_WIDTH-1:0] w_sat;
  logic [ADDR_WIDTH:0]          w_play_next;

  assign w_strobe_play = bus.audio_valid_in & ~bus.record_in;

  // Delay of the tap being issued this cycle (issue index k selects tap k).
  always_comb begin
    w_sel_delay = '0;
    for (int k = 0; k < NUM_TAPS; k++) begin
      if (r_issue_idx == c_IDX_W'(k + 1)) begin
        w_sel_delay = r_delay[k];
      end
    end
  end

  // A tap reaching back before the start of the take is muted, never wrapped.
  assign w_sel_skip = (w_sel_delay == '0) || (w_sel_delay > r_base_ptr);
  assign w_sel_addr = r_base_ptr - w_sel_delay;

  read_tag_pipe #(
    .DEPTH     (READ_LATENCY),
    .IDX_WIDTH (c_IDX_W)
  ) u_read_tag_pipe (
    .clk_in        (clk_in),
    .rst_in        (rst_in),
    .tag_valid_in  (r_tag_valid),
    .tag_idx_in    (r_tag_idx),
    .tag_skip_in   (r_tag_skip),
    .tag_valid_out (w_ret_valid),
    .tag_idx_out   (w_ret_idx),
    .tag_skip_out  (w_ret_skip)
  );

  // Returned sample attenuated by 2^-k for tap k; the dry read has k = 0.
  assign w_ret_ext   = {{(c_ACC_W-DATA_WIDTH){bus.rd_data_in[DATA_WIDTH-1]}}, bus.rd_data_in};
  assign w_ret_shift = w_ret_ext >>> w_ret_idx;
  assign w_contrib   = w_ret_skip ? '0 : w_ret_shift;
  assign w_sum       = r_acc + w_contrib;
  assign w_sat       = DATA_WIDTH'(sat_to_width(32'(w_sum), DATA_WIDTH));
  assign w_play_next = {1'b0, r_play_ptr} + (ADDR_WIDTH+1)'(1);

  // Playback sequencer: issue dry + tap reads, accumulate returns, emit sample.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_state       <= IDLE;
      r_play_ptr    <= '0;
      r_base_ptr    <= '0;
      r_issue_idx   <= '0;
      r_rd_addr     <= '0;
      r_tag_valid   <= 1'b0;
      r_tag_idx     <= '0;
      r_tag_skip    <= 1'b0;
      r_acc         <= '0;
      r_audio_out   <= '0;
      r_audio_valid <= 1'b0;
      r_overrun     <= 1'b0;
      for (int k = 0; k < NUM_TAPS; k++) begin
        r_delay[k] <= '0;
      end
    end else begin
      r_tag_valid   <= 1'b0;
      r_audio_valid <= 1'b0;

      if (w_strobe_play && (r_state != IDLE)) begin
        r_overrun <= 1'b1;
      end

      if (w_ret_valid) begin
        r_acc <= w_sum;
      end

      case (r_state)
        IDLE: begin
          if (w_strobe_play) begin
            for (int k = 0; k < NUM_TAPS; k++) begin
              r_delay[k] <= bus.tap_delay_in[k*ADDR_WIDTH +: ADDR_WIDTH];
            end
            r_base_ptr  <= r_play_ptr;
            r_acc       <= '0;
            r_rd_addr   <= r_play_ptr;
            r_tag_valid <= 1'b1;
            r_tag_idx   <= '0;
            // With nothing recorded the dry read is muted too, giving silence.
            r_tag_skip  <= (r_rec_len == '0);
            r_issue_idx <= c_IDX_W'(1);
            r_state     <= ISSUE;
          end
        end
        ISSUE: begin
          r_rd_addr   <= w_sel_addr;
          r_tag_valid <= 1'b1;
          r_tag_idx   <= r_issue_idx;
          r_tag_skip  <= w_sel_skip;
          if (r_issue_idx == c_IDX_W'(NUM_TAPS)) begin
            r_state <= DRAIN;
          end else begin
            r_issue_idx <= r_issue_idx + c_IDX_W'(1);
          end
        end
        DRAIN: begin
          if (w_ret_valid && (w_ret_idx == c_IDX_W'(NUM_TAPS))) begin
            r_audio_out   <= w_sat;
            r_audio_valid <= 1'b1;
            r_state       <= OUT;
          end
        end
        OUT: begin
          r_state <= IDLE;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase

      // Starting a new take rewinds playback and wins over the advance.
      if (w_rec_rise) begin
        r_play_ptr <= '0;
      end else if ((r_state == OUT) && (r_rec_len != '0)) begin
        r_play_ptr <= (w_play_next >= r_rec_len) ? '0 : w_play_next[ADDR_WIDTH-1:0];
      end
    end
  end

  assign bus.rd_addr_out     = r_rd_addr;
  assign bus.audio_out       = r_audio_out;
  assign bus.audio_valid_out = r_audio_valid;
  assign bus.overrun_out     = r_overrun;

endmodule
`default_nettype wire

// File: tb/tb_audio_buffer_scheduler.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_audio_buffer_scheduler                                     |
// | Purpose  : Self-checking bench: BRAM model, sample-level reference       |
// |            model of the recorded take and the echo mix.                  |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module tb_audio_buffer_scheduler;

  localparam int c_AW   = 16;
  localparam int c_DW   = 8;
  localparam int c_TAPS = 2;
  localparam int c_LAT  = 2;
  localparam int c_DEPTH = 1 << c_AW;

  logic clk_in = 1'b0;
  logic rst_in = 1'b1;

  audio_buffer_scheduler_if #(.ADDR_WIDTH(c_AW), .DATA_WIDTH(c_DW), .NUM_TAPS(c_TAPS)) bus ();

  audio_buffer_scheduler #(
    .ADDR_WIDTH   (c_AW),
    .DATA_WIDTH   (c_DW),
    .NUM_TAPS     (c_TAPS),
    .READ_LATENCY (c_LAT)
  ) dut (
    .clk_in (clk_in),
    .rst_in (rst_in),
    .bus    (bus)
  );

  always #5 clk_in = ~clk_in;

  // BRAM: port A write, port B read with two-cycle latency.
  logic [c_DW-1:0] bram [c_DEPTH];
  logic [c_DW-1:0] rd_p1 = '0;
  logic [c_DW-1:0] rd_p2 = '0;
  always @(posedge clk_in) begin
    if (bus.wr_en_out) bram[bus.wr_addr_out] <= bus.wr_data_out;
    rd_p1 <= bram[bus.rd_addr_out];
    rd_p2 <= rd_p1;
  end
  assign bus.rd_data_in = rd_p2;

  // Reference model state.
  int ref_mem [c_DEPTH];
  int ref_len;
  int ref_play;
  int ref_delay [c_TAPS];

  int errors = 0;
  int checks = 0;

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  // Expected mix at the current play position from the recorded take.
  function automatic int ref_mix();
    int s;
    int d;
    if (ref_len == 0) return 0;
    s = ref_mem[ref_play];
    for (int k = 1; k <= c_TAPS; k++) begin
      d = ref_delay[k-1];
      if (d != 0 && d <= ref_play) s += ref_mem[ref_play - d] >>> k;
    end
    if (s > 127) s = 127;
    if (s < -128) s = -128;
    return s;
  endfunction

  function automatic void ref_advance();
    if (ref_len != 0) ref_play = (ref_play + 1 >= ref_len) ? 0 : ref_play + 1;
  endfunction

  task automatic set_taps(input int d1, input int d2);
    ref_delay[0] = d1;
    ref_delay[1] = d2;
    for (int k = 0; k < c_TAPS; k++) bus.tap_delay_in[k*c_AW +: c_AW] = c_AW'(ref_delay[k]);
  endtask

  // Start a new take and record n samples. mode 0: constant val, 1: 1..n, 2: random.
  task automatic rec_block(input int n, input int mode, input int val);
    logic [c_DW-1:0] rb;
    bit exp_en;
    bus.record_in = 1'b0;
    bus.audio_valid_in = 1'b0;
    tick();
    bus.record_in = 1'b1;
    ref_len = 0;
    ref_play = 0;
    for (int i = 0; i < n; i++) begin
      case (mode)
        0: rb = c_DW'(val);
        1: rb = c_DW'(i + 1);
        default: rb = c_DW'($urandom);
      endcase
      bus.audio_in = rb;
      bus.audio_valid_in = 1'b1;
      #1;
      exp_en = (ref_len < c_DEPTH);
      if (i < 4 || i >= n - 2) begin
        chk("wr_en", int'(bus.wr_en_out), int'(exp_en));
        chk("full_before_write", int'(bus.full_out), int'(ref_len == c_DEPTH));
        if (exp_en) begin
          chk("wr_addr", int'(bus.wr_addr_out), ref_len);
          chk("wr_data", int'(bus.wr_data_out), int'(rb));
        end
      end
      if (exp_en) begin
        ref_mem[ref_len] = int'($signed(rb));
        ref_len++;
      end
      tick();
    end
    bus.audio_valid_in = 1'b0;
    bus.record_in = 1'b0;
    chk("rec_length", int'(bus.rec_length_out), ref_len);
  endtask

  // One well-spaced playback strobe; checks latency, value and pulse width.
  task automatic play(input string tag, output int obs);
    int lat;
    int exp;
    bit seen;
    exp = ref_mix();
    bus.record_in = 1'b0;
    bus.audio_valid_in = 1'b1;
    tick();
    bus.audio_valid_in = 1'b0;
    lat = 1;
    seen = 0;
    obs = 9999;
    while (!seen && lat < 20) begin
      if (bus.audio_valid_out) begin
        seen = 1;
        obs = int'($signed(bus.audio_out));
      end else begin
        tick();
        lat++;
      end
    end
    chk({tag, "_latency"}, lat, 6);
    chk(tag, obs, exp);
    tick();
    chk({tag, "_pulse_width"}, int'(bus.audio_valid_out), 0);
    ref_advance();
  endtask

  initial begin : watchdog
    #5ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : stim
    int obs;
    int pulses;
    int val;
    bus.audio_in = '0;
    bus.audio_valid_in = 1'b0;
    bus.record_in = 1'b0;
    bus.tap_delay_in = '0;
    ref_len = 0;
    ref_play = 0;
    set_taps(0, 0);
    repeat (3) tick();
    rst_in = 1'b0;

    // Reset state.
    chk("rst_audio_out", int'(bus.audio_out), 0);
    chk("rst_audio_valid", int'(bus.audio_valid_out), 0);
    chk("rst_rec_length", int'(bus.rec_length_out), 0);
    chk("rst_full", int'(bus.full_out), 0);
    chk("rst_overrun", int'(bus.overrun_out), 0);
    chk("rst_rd_addr", int'(bus.rd_addr_out), 0);
    chk("rst_wr_en", int'(bus.wr_en_out), 0);

    // Samples 1..8, taps disabled; ninth strobe wraps to the first sample.
    rec_block(8, 1, 0);
    set_taps(0, 0);
    for (int i = 0; i < 9; i++) begin
      play("dry", obs);
      chk("dry_const", obs, (i % 8) + 1);
    end
    chk("no_overrun_at_min_spacing", int'(bus.overrun_out), 0);

    // Random take, random tap delays per strobe (some beyond the take start).
    rec_block(400, 2, 0);
    for (int i = 0; i < 420; i++) begin
      set_taps(($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(1, 450)),
               ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(1, 450)));
      play("rand_mix", obs);
    end

    // Constant 64 take: both taps live -> 112, far tap muted -> 96.
    rec_block(400, 0, 64);
    set_taps(150, 300);
    for (int i = 0; i <= 350; i++) begin
      play("const_mix", obs);
      if (i == 200) chk("far_tap_skipped", obs, 96);
      if (i == 350) chk("both_taps", obs, 112);
    end

    // Saturation both ways.
    rec_block(4, 0, 127);
    set_taps(1, 2);
    for (int i = 0; i < 3; i++) play("sat_pos", obs);
    chk("sat_pos_clamp", obs, 127);
    rec_block(4, 0, -128);
    for (int i = 0; i < 3; i++) play("sat_neg", obs);
    chk("sat_neg_clamp", obs, -128);

    // Second strobe two cycles after the first is dropped.
    val = ref_mix();
    bus.audio_valid_in = 1'b1;
    tick();
    bus.audio_valid_in = 1'b0;
    tick();
    bus.audio_valid_in = 1'b1;
    tick();
    bus.audio_valid_in = 1'b0;
    pulses = 0;
    obs = 9999;
    for (int i = 0; i < 12; i++) begin
      if (bus.audio_valid_out) begin
        pulses++;
        obs = int'($signed(bus.audio_out));
      end
      tick();
    end
    ref_advance();
    chk("overrun_pulses", pulses, 1);
    chk("overrun_value", obs, val);
    chk("overrun_flag", int'(bus.overrun_out), 1);

    // Reset while the sequence is draining.
    bus.audio_valid_in = 1'b1;
    tick();
    bus.audio_valid_in = 1'b0;
    repeat (3) tick();
    rst_in = 1'b1;
    tick();
    chk("drain_rst_audio_out", int'(bus.audio_out), 0);
    chk("drain_rst_valid", int'(bus.audio_valid_out), 0);
    chk("drain_rst_rd_addr", int'(bus.rd_addr_out), 0);
    chk("drain_rst_rec_length", int'(bus.rec_length_out), 0);
    chk("drain_rst_overrun", int'(bus.overrun_out), 0);
    rst_in = 1'b0;
    pulses = 0;
    for (int i = 0; i < 8; i++) begin
      if (bus.audio_valid_out) pulses++;
      tick();
    end
    chk("drain_rst_no_pulse", pulses, 0);
    ref_len = 0;
    ref_play = 0;
    play("empty_take", obs);
    chk("empty_take_silent", obs, 0);

    // Fill the whole buffer plus one extra strobe.
    rec_block(c_DEPTH + 1, 2, 0);
    chk("full_flag", int'(bus.full_out), 1);
    chk("full_length", int'(bus.rec_length_out), c_DEPTH);
    set_taps(5, 0);
    play("full_play", obs);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
